fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Double-buffered coefficient loader for the channelizer FIR in chan_550_packet. Software writes packed coefficient pairs (e.g. b16/b17) and control words through ppc2simulink registers. This block writes them into a shadow bank. It swaps shadow and active banks only on a frame sync, so the FIR never sees a half-updated set of coefficients.

## Interface

**Parameters**
- N_PAIRS, default 16: number of 32-bit coefficient pairs per bank.
- ADDR_W, default 4: pair-index width; must equal clog2(N_PAIRS).

**Ports**
- `user_clk` in 1: single clock for the block.
- `user_rst_n` in 1: reset; asynchronous, active-low.
- `sw_data` in 32: packed pair from a software register. [31:16] = even tap, [15:0] = odd tap, each signed 16-bit.
- `sw_ctrl` in 32: control word from a software register.
  - [ADDR_W-1:0] = pair index.
  - [8] = write toggle.
  - [9] = commit toggle.
  - All other bits ignored.
- `sync_in` in 1: frame-boundary pulse from the datapath. Asserted one cycle before the first tap read of a frame.
- `rd_addr` in ADDR_W: FIR pair read index.
- `rd_data` out 32: active-bank pair at `rd_addr`.
- `active_bank` out 1: bank the FIR is currently reading.
- `swap_pending` out 1: a commit has been accepted and is waiting for `sync_in`.
- `status` out 32: software-readable status.
  - [15:8] = error count, saturating at 255.
  - [1] = `swap_pending`.
  - [0] = `active_bank`.
  - All other bits 0.

## Operation

**Edge detection**
- Registers `prev_wr` and `prev_cm` hold the previous values of `sw_ctrl[8]` and `sw_ctrl[9]`.
- An edge is either transition of a toggle bit (XOR of current and previous value).
- In the first cycle after reset release, both registers load `sw_ctrl` and no action is taken. A stale toggle level therefore never causes a spurious write.

**State machine**
- IDLE:
  - Write edge: store `sw_data` at shadow[`sw_ctrl` index]. The shadow bank is the bank not selected by `active_bank`. Set that pair's bit in `wr_mask`.
  - Commit edge: go to ARMED.
  - Write edge and commit edge in the same cycle: the write is performed first, then the block goes to ARMED. The write is included in the commit.
- ARMED:
  - `swap_pending` = 1.
  - Write or commit edges: dropped, and the error count increments by 1 per cycle containing a dropped edge.
  - `sync_in` = 1: go to SWAP.
- SWAP (one cycle): toggle `active_bank`, clear `wr_mask`, go to IDLE.

**Other rules**
- Index ≥ N_PAIRS: the write is dropped and the error count increments.
- `sync_in` while in IDLE is ignored.
- A commit edge that arrives in the same cycle as `sync_in` waits for the next `sync_in`.
- Bank contents are not reset. After a swap, the new shadow bank holds stale data; software rewrites every pair before the next commit.
- Reset values: state IDLE, `active_bank` 0, `swap_pending` 0, `rd_data` 0, error count 0, `wr_mask` 0.
- Reset asserted mid-operation: ARMED is abandoned, no swap occurs, and `active_bank` returns to 0.

## Timing

- Read latency is 1 cycle:
  - `rd_addr` at cycle t gives `rd_data` at t+1.
  - Data comes from the bank that `active_bank` selected at cycle t.
- Write edge sampled at cycle t:
  - The write is visible in the shadow bank from t+1.
  - It can be read through `rd_data` only after a swap.
- Commit edge at t: `swap_pending` = 1 at t+1.
- `sync_in` at cycle s while ARMED:
  - State = SWAP at s+1.
  - `active_bank` toggles and `swap_pending` falls at s+2.
  - Reads issued at s+2 onward use the new bank.
  - The datapath's one-cycle sync lead covers this delay.
- Error count updates 1 cycle after the offending edge. `status` is registered and follows the internal state by 1 cycle.

## Configuration

- `FIR_COEF_LOADER_FULLCHK_EN` defined:
  - A commit edge in IDLE is accepted only if `wr_mask` is all ones (all N_PAIRS written since the last swap).
  - Otherwise the commit is rejected: the error count increments and the state stays IDLE.
- Not defined:
  - `wr_mask` logic is removed.
  - Every commit in IDLE is accepted.

## Structure

- Package `fir_coef_pkg` holds:
  - The state enum (IDLE, ARMED, SWAP).
  - Control bit positions (WR_BIT=8, CM_BIT=9).
  - COEF_W=16 and the error-count width (8).
- Sub-module `coef_bank_ram` is a simple dual-port RAM of 2·N_PAIRS × 32 bits:
  - Address MSB is the bank bit.
  - One write port (shadow bank).
  - One registered read port (active bank).

## Test plan

- **Basic swap:**
  - Stimulus: after reset, write 16 pairs with value 0x00010000·i+i, commit, pulse `sync_in`.
  - Response: `active_bank`=1 two cycles later; `rd_addr`=5 returns 0x00050005 one cycle after the read.
- **Sync before commit:** `sync_in` pulsed with no commit → `active_bank` stays 0, error count 0.
- **Write while ARMED:**
  - Stimulus: commit, then write pair 3 = 0xDEADBEEF while ARMED, then sync.
  - Response: error count = 1; pair 3 in the new active bank is unchanged.
- **Simultaneous edges:**
  - Stimulus: write toggle and commit toggle in the same cycle (pair 2 = 0x12345678), sync at s.
  - Response: `rd_data` at pair 2 = 0x12345678 from s+3 (read issued at s+2).
- **Full-set check (with `FIR_COEF_LOADER_FULLCHK_EN`):**
  - Stimulus: write 15 of 16 pairs, then commit.
  - Response: error count = 1, `swap_pending` stays 0. After writing the 16th pair and committing again, `swap_pending`=1.
- **Reset mid-swap:** reset asserted while ARMED → `swap_pending`=0, `active_bank`=0, `status`=0.

Source files
------------

// File: rtl/fir_coef_pkg.sv
// Shared types and constants for the double-buffered FIR coefficient loader.
package fir_coef_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SWAP
  } state_t;

  localparam int WR_BIT = 8;
  localparam int CM_BIT = 9;
  localparam int COEF_W = 16;
  localparam int ERR_W  = 8;

endpackage

// File: rtl/coef_bank_ram.sv
// Two-bank coefficient store: one write port into the shadow bank, one
// registered read port from the active bank. Address MSB selects the bank.
module coef_bank_ram
  import fir_coef_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W:0]     wr_addr,
  input  logic [2*COEF_W-1:0] wr_data,
  input  logic [ADDR_W:0]     rd_addr,
  output logic [2*COEF_W-1:0] rd_data
);

  // Depth is 2*N_PAIRS whenever N_PAIRS is a power of two.
  logic [2*COEF_W-1:0] mem [2**(ADDR_W+1)];

  // NOTE: the array has no reset so it can map onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader: software fills the shadow bank and a
// commit arms a swap that only happens on the next frame sync.
// Build macro FIR_COEF_LOADER_FULLCHK_EN: commit accepted only once every pair is written.
module fir_coef_loader
  import fir_coef_pkg::*;
#(
  parameter int N_PAIRS = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       sw_data,
  input  logic [31:0]       sw_ctrl,
  input  logic              sync_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              active_bank,
  output logic              swap_pending,
  output logic [31:0]       status
);

  state_t            state, state_next;
  logic              edge_en, prev_wr, prev_cm;
  logic              wr_edge, cm_edge;
  logic [ADDR_W-1:0] wr_idx;
  logic              idx_ok, commit_ok;
  logic              ram_we, err_inc, accept, do_swap;
  logic [ERR_W-1:0]  err_cnt;
  logic              unused_ctrl;

  assign unused_ctrl = ^{sw_ctrl[31:CM_BIT+1], sw_ctrl[WR_BIT-1:ADDR_W]};

  assign wr_idx  = sw_ctrl[ADDR_W-1:0];
  assign wr_edge = edge_en & (sw_ctrl[WR_BIT] ^ prev_wr);
  assign cm_edge = edge_en & (sw_ctrl[CM_BIT] ^ prev_cm);
  assign idx_ok  = ({1'b0, wr_idx} < (ADDR_W+1)'(N_PAIRS));
  assign ram_we  = (state == IDLE) && wr_edge && idx_ok;
  assign do_swap = (state == SWAP);

  // First cycle after reset only captures the toggle levels, so a stale level is never an edge.
  // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the block order.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      edge_en <= 1'b0;
      prev_wr <= 1'b0;
      prev_cm <= 1'b0;
    end else begin
      edge_en <= 1'b1;
      prev_wr <= sw_ctrl[WR_BIT];
      prev_cm <= sw_ctrl[CM_BIT];
    end
  end

`ifdef FIR_COEF_LOADER_FULLCHK_EN
  logic [N_PAIRS-1:0] wr_mask, wr_onehot;

  always_comb begin
    wr_onehot = '0;
    if (ram_we) wr_onehot[wr_idx] = 1'b1;
  end

  // A write in the same cycle as the commit counts towards the full set.
  assign commit_ok = &(wr_mask | wr_onehot);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)  wr_mask <= '0;
    else if (do_swap) wr_mask <= '0;
    else              wr_mask <= wr_mask | wr_onehot;
  end
`else
  assign commit_ok = 1'b1;
`endif

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_edge && !idx_ok) err_inc = 1'b1;
        if (cm_edge) begin
          if (commit_ok) begin
            accept     = 1'b1;
            state_next = ARMED;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ARMED: begin
        if (wr_edge || cm_edge) err_inc = 1'b1;
        if (sync_in) state_next = SWAP;
      end
      SWAP: begin
        if (wr_edge || cm_edge) err_inc = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      err_cnt      <= '0;
      status       <= '0;
    end else begin
      active_bank <= active_bank ^ do_swap;
      if (accept)       swap_pending <= 1'b1;
      else if (do_swap) swap_pending <= 1'b0;
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      status <= {16'h0000, err_cnt, 6'b000000, swap_pending, active_bank};
    end
  end

  coef_bank_ram #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .we     (ram_we),
    .wr_addr({~active_bank, wr_idx}),
    .wr_data(sw_data),
    .rd_addr({active_bank, rd_addr}),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: a bank model feeds a read scoreboard,
// control and status outputs are compared inline in each scenario task.
module tb_fir_coef_loader;

  localparam int N_PAIRS = 16;
  localparam int ADDR_W  = 4;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       sw_data;
  logic [31:0]       sw_ctrl;
  logic              sync_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              active_bank;
  logic              swap_pending;
  logic [31:0]       status;

  int                n_cmp = 0;
  int                n_err = 0;
  int                exp_err = 0;
  logic              wr_tog = 1'b0;
  logic              cm_tog = 1'b0;
  logic [ADDR_W-1:0] cur_idx = '0;
  logic              mdl_active = 1'b0;
  logic [31:0]       mdl_bank [2][N_PAIRS];
  logic [31:0]       sb [$];
  logic [31:0]       exp_val;

  always #5 user_clk = ~user_clk;

  fir_coef_loader #(
    .N_PAIRS(N_PAIRS),
    .ADDR_W (ADDR_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .sw_data     (sw_data),
    .sw_ctrl     (sw_ctrl),
    .sync_in     (sync_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .active_bank (active_bank),
    .swap_pending(swap_pending),
    .status      (status)
  );

  // Called at a falling edge; drives one cycle of control and returns at the next falling edge.
  task automatic drive_ctrl(input logic [ADDR_W-1:0] idx, input logic [31:0] data,
                            input logic do_wr, input logic do_cm);
    cur_idx = idx;
    sw_data = data;
    if (do_wr) wr_tog = ~wr_tog;
    if (do_cm) cm_tog = ~cm_tog;
    sw_ctrl = {22'h0, cm_tog, wr_tog, 4'h0, cur_idx};
    @(negedge user_clk);
  endtask

  task automatic write_shadow(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
    mdl_bank[mdl_active ^ 1'b1][idx] = data;
    drive_ctrl(idx, data, 1'b1, 1'b0);
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    @(negedge user_clk);
    sync_in = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] addr);
    rd_addr = addr;
    sb.push_back(mdl_bank[mdl_active][addr]);
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    repeat (3) @(negedge user_clk);
    n_cmp++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL reset_bank: got %b expected 0", active_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b expected 0", swap_pending); end
    n_cmp++; if (status !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 00000000", status); end
    n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data); end
    user_rst_n = 1'b1;
    @(negedge user_clk);
  endtask

  task automatic test_basic_swap();
    for (int i = 0; i < N_PAIRS; i++) write_shadow(ADDR_W'(i), (32'h0001_0000 * i) + i);
    drive_ctrl(cur_idx, sw_data, 1'b0, 1'b1);
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL basic_armed: got %b expected 1", swap_pending); end
    pulse_sync();
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL basic_swap_cycle_bank: got %b expected %b", active_bank, mdl_active); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL basic_swap_cycle_pending: got %b expected 1", swap_pending); end
    @(negedge user_clk);
    mdl_active ^= 1'b1;
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL basic_new_bank: got %b expected %b", active_bank, mdl_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL basic_pending_fall: got %b expected 0", swap_pending); end
    issue_read(ADDR_W'(5));
    @(negedge user_clk);
    exp_val = sb.pop_front();
    n_cmp++; if (rd_data !== exp_val) begin n_err++; $display("FAIL basic_read5: got %h expected %h", rd_data, exp_val); end
    n_cmp++; if (status !== 32'h0000_0001) begin n_err++; $display("FAIL basic_status: got %h expected 00000001", status); end
    issue_read('0);
    for (int i = 1; i <= N_PAIRS; i++) begin
      @(negedge user_clk);
      exp_val = sb.pop_front();
      n_cmp++; if (rd_data !== exp_val) begin n_err++; $display("FAIL basic_sweep[%0d]: got %h expected %h", i - 1, rd_data, exp_val); end
      if (i < N_PAIRS) issue_read(ADDR_W'(i));
    end
  endtask

  task automatic test_sync_no_commit();
    pulse_sync();
    repeat (3) @(negedge user_clk);
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL idle_sync_bank: got %b expected %b", active_bank, mdl_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL idle_sync_pending: got %b expected 0", swap_pending); end
    n_cmp++; if (status !== {16'h0, 8'(exp_err), 6'b0, 1'b0, mdl_active}) begin
      n_err++; $display("FAIL idle_sync_status: got %h expected %h", status, {16'h0, 8'(exp_err), 6'b0, 1'b0, mdl_active});
    end
  endtask

  task automatic test_write_while_armed();
    for (int i = 0; i < N_PAIRS; i++) write_shadow(ADDR_W'(i), 32'hA000_0000 | i);
    drive_ctrl(cur_idx, sw_data, 1'b0, 1'b1);
    drive_ctrl(ADDR_W'(3), 32'hDEAD_BEEF, 1'b1, 1'b0);
    exp_err++;
    @(negedge user_clk);
    n_cmp++; if (status[15:8] !== 8'(exp_err)) begin n_err++; $display("FAIL armed_err_count: got %0d expected %0d", status[15:8], exp_err); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL armed_still_pending: got %b expected 1", swap_pending); end
    pulse_sync();
    @(negedge user_clk);
    mdl_active ^= 1'b1;
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL armed_bank: got %b expected %b", active_bank, mdl_active); end
    issue_read(ADDR_W'(3));
    @(negedge user_clk);
    exp_val = sb.pop_front();
    n_cmp++; if (rd_data !== exp_val) begin n_err++; $display("FAIL armed_pair3: got %h expected %h", rd_data, exp_val); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < N_PAIRS; i++) if (i != 2) write_shadow(ADDR_W'(i), 32'hB000_0000 | i);
    mdl_bank[mdl_active ^ 1'b1][2] = 32'h1234_5678;
    drive_ctrl(ADDR_W'(2), 32'h1234_5678, 1'b1, 1'b1);
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL simul_armed: got %b expected 1", swap_pending); end
    repeat (2) @(negedge user_clk);
    pulse_sync();
    issue_read(ADDR_W'(2));
    @(negedge user_clk);
    exp_val = sb.pop_front();
    n_cmp++; if (rd_data !== exp_val) begin n_err++; $display("FAIL simul_old_bank_read: got %h expected %h", rd_data, exp_val); end
    mdl_active ^= 1'b1;
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL simul_bank: got %b expected %b", active_bank, mdl_active); end
    issue_read(ADDR_W'(2));
    @(negedge user_clk);
    exp_val = sb.pop_front();
    n_cmp++; if (rd_data !== exp_val) begin n_err++; $display("FAIL simul_new_read: got %h expected %h", rd_data, exp_val); end
  endtask

  task automatic test_full_set();
    for (int i = 0; i < N_PAIRS - 1; i++) write_shadow(ADDR_W'(i), 32'hC000_0000 | i);
    drive_ctrl(cur_idx, sw_data, 1'b0, 1'b1);
`ifdef FIR_COEF_LOADER_FULLCHK_EN
    exp_err++;
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL full_reject_pending: got %b expected 0", swap_pending); end
    @(negedge user_clk);
    n_cmp++; if (status[15:8] !== 8'(exp_err)) begin n_err++; $display("FAIL full_reject_err: got %0d expected %0d", status[15:8], exp_err); end
    write_shadow(ADDR_W'(N_PAIRS - 1), 32'hC000_000F);
    drive_ctrl(cur_idx, sw_data, 1'b0, 1'b1);
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL full_accept_pending: got %b expected 1", swap_pending); end
`else
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL partial_accept_pending: got %b expected 1", swap_pending); end
`endif
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 300; i++) drive_ctrl(cur_idx, sw_data, 1'b1, 1'b0);
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    @(negedge user_clk);
    n_cmp++; if (status[15:8] !== 8'(exp_err)) begin n_err++; $display("FAIL err_saturate: got %0d expected %0d", status[15:8], exp_err); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL err_sat_pending: got %b expected 1", swap_pending); end
    n_cmp++; if (active_bank !== mdl_active) begin n_err++; $display("FAIL err_sat_bank: got %b expected %b", active_bank, mdl_active); end
  endtask

  task automatic test_reset_mid_swap();
    user_rst_n = 1'b0;
    wr_tog = 1'b1;
    cm_tog = 1'b1;
    sw_ctrl = {22'h0, cm_tog, wr_tog, 4'h0, cur_idx};
    #1;
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL rst_mid_pending: got %b expected 0", swap_pending); end
    n_cmp++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL rst_mid_bank: got %b expected 0", active_bank); end
    n_cmp++; if (status !== 32'h0) begin n_err++; $display("FAIL rst_mid_status: got %h expected 00000000", status); end
    repeat (2) @(negedge user_clk);
    user_rst_n = 1'b1;
    mdl_active = 1'b0;
    exp_err = 0;
    repeat (3) @(negedge user_clk);
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL rst_stale_commit: got %b expected 0", swap_pending); end
    n_cmp++; if (status !== 32'h0) begin n_err++; $display("FAIL rst_stale_status: got %h expected 00000000", status); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    user_rst_n = 1'b0;
    sw_data    = '0;
    sw_ctrl    = '0;
    sync_in    = 1'b0;
    rd_addr    = '0;
    @(negedge user_clk);
    test_reset();
    test_basic_swap();
    test_sync_no_commit();
    test_write_while_armed();
    test_simultaneous();
    test_full_set();
    test_err_saturate();
    test_reset_mid_swap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
